video_timing_gen: RTL and testbench

Raster timing and pixel-alignment stage directly upstream of the HDMI transmitter pins. It counts horizontal and vertical positions, requests pixels from a one-cycle-latency source by (x, y), and drives DE/HS/VS plus 24-bit RGB, all mutually aligned, to HDMI_TX_*. It also accepts the mode-change pulse from the resolution selector as a frame restart.

---
 rtl/video_timing_pkg.sv | 46 ++++
 rtl/video_sync_counter.sv | 60 ++++++
 rtl/video_timing_gen.sv | 149 ++++++++++++++
 tb/tb_video_timing_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator: 12-bit coordinates,
// 640x480@60 default timing and the colour-bar palette used when VIDEO_TIMING_PATTERN_EN is defined.
package video_timing_pkg;

  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam bit DEF_HS_POL   = 1'b0;
  localparam bit DEF_VS_POL   = 1'b0;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  localparam logic [0:7][23:0] BAR_COLOURS = {
    COL_WHITE, COL_YELLOW, COL_CYAN, COL_GREEN,
    COL_MAGENTA, COL_RED, COL_BLUE, COL_BLACK
  };

  // Threshold compare instead of a divide; columns past the 8th bar stay on the last colour.
  function automatic logic [23:0] bar_colour(input coord_t x, input coord_t bar_w);
    logic [2:0] idx;
    idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (x >= coord_t'(k) * bar_w) idx = 3'(k);
    end
    return BAR_COLOURS[idx];
  endfunction

endpackage

// File: rtl/video_sync_counter.sv
// Horizontal/vertical position counters with frame restart; a restart seen while
// clk_en is low is held pending until the next enabled edge.
module video_sync_counter
  import video_timing_pkg::*;
#(
  parameter int H_TOTAL = DEF_H_TOTAL,
  parameter int V_TOTAL = DEF_V_TOTAL
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_en,
  input  logic               restart,
  output logic [COORD_W-1:0] h_cnt,
  output logic [COORD_W-1:0] v_cnt
);

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  coord_t h_q, h_d;
  coord_t v_q, v_d;
  logic   pending_q, pending_d;

  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    pending_d = pending_q;
    if (clk_en) begin
      pending_d = 1'b0;
      // Restart and the natural wrap both land on (0,0), so they coincide into one frame start.
      if (restart || pending_q) begin
        h_d = '0;
        v_d = '0;
      end else if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end else if (restart) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q       <= '0;
      v_q       <= '0;
      pending_q <= 1'b0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      pending_q <= pending_d;
    end
  end

  assign h_cnt = h_q;
  assign v_cnt = v_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing and pixel alignment for the HDMI transmitter: counters -> request stage -> output stage.
// Define VIDEO_TIMING_PATTERN_EN to replace pix_rgb with internal colour bars.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = DEF_HS_POL,
  parameter bit VS_POL   = DEF_VS_POL
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_en,
  input  logic               restart,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_req,
  input  logic [23:0]        pix_rgb,
  output logic               vid_de,
  output logic               vid_hs,
  output logic               vid_vs,
  output logic [23:0]        vid_rgb,
  output logic               frame_start,
  output logic               line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG_C = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END_C = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG_C = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END_C = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t h_cnt, v_cnt;

  video_sync_counter #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL)
  ) u_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .clk_en (clk_en),
    .restart(restart),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt)
  );

  // Request stage
  coord_t pix_x_q, pix_x_d;
  coord_t pix_y_q, pix_y_d;
  logic   pix_req_q, pix_req_d;
  logic   hs_raw_q, hs_raw_d;
  logic   vs_raw_q, vs_raw_d;
  logic   frame_start_q, frame_start_d;
  logic   line_start_q, line_start_d;

  // Output stage
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [23:0] rgb_q, rgb_d;

`ifdef VIDEO_TIMING_PATTERN_EN
  localparam coord_t BAR_W_C = coord_t'(H_ACTIVE / 8);
  logic unused_pix_rgb;
  assign unused_pix_rgb = ^pix_rgb;
`endif

  always_comb begin
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    pix_req_d     = pix_req_q;
    hs_raw_d      = hs_raw_q;
    vs_raw_d      = vs_raw_q;
    frame_start_d = 1'b0;
    line_start_d  = 1'b0;
    de_d          = de_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    rgb_d         = rgb_q;
    if (clk_en) begin
      pix_x_d       = h_cnt;
      pix_y_d       = v_cnt;
      pix_req_d     = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
      hs_raw_d      = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
      vs_raw_d      = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      line_start_d  = (h_cnt == '0);

      de_d = pix_req_q;
      hs_d = hs_raw_q ? HS_POL : ~HS_POL;
      vs_d = vs_raw_q ? VS_POL : ~VS_POL;
`ifdef VIDEO_TIMING_PATTERN_EN
      rgb_d = pix_req_q ? bar_colour(pix_x_q, BAR_W_C) : 24'h0;
`else
      // The source answers the request currently on pix_x/pix_y, so sampling here keeps RGB aligned with DE.
      rgb_d = pix_req_q ? pix_rgb : 24'h0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_req_q     <= 1'b0;
      hs_raw_q      <= 1'b0;
      vs_raw_q      <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      de_q          <= 1'b0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      rgb_q         <= '0;
    end else begin
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_req_q     <= pix_req_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      de_q          <= de_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      rgb_q         <= rgb_d;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_req     = pix_req_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign vid_de      = de_q;
  assign vid_hs      = hs_q;
  assign vid_vs      = vs_q;
  assign vid_rgb     = rgb_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default horizontal timing, shortened vertical timing to keep
// full frames cheap; outputs compared every cycle against a linear-position raster model.
module tb_video_timing_gen;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 24;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 4;
  localparam bit HS_POL   = 1'b0;
  localparam bit VS_POL   = 1'b0;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic        clk, reset_n, clk_en, restart;
  logic [11:0] pix_x, pix_y;
  logic        pix_req;
  logic [23:0] pix_rgb;
  logic        vid_de, vid_hs, vid_vs;
  logic [23:0] vid_rgb;
  logic        frame_start, line_start;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .restart(restart),
    .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req), .pix_rgb(pix_rgb),
    .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_rgb(vid_rgb),
    .frame_start(frame_start), .line_start(line_start)
  );

  // Pixel source: answers the current request with a coordinate-tagged value.
  assign pix_rgb = {pix_x[7:0], pix_y[7:0], 8'hA5};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: raster position as one linear index into the frame.
  int          pos;
  bit          pend;
  int          m1_x, m1_y;
  bit          m1_req, m1_hs, m1_vs, m1_fs, m1_ls;
  bit          m2_de, m2_hs, m2_vs;
  logic [23:0] m2_rgb;

  function automatic logic [23:0] exp_colour(input int x, input int y);
`ifdef VIDEO_TIMING_PATTERN_EN
    int bar;
    logic [23:0] pal [8];
    pal = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    bar = x / (H_ACTIVE / 8);
    if (bar > 7) bar = 7;
    if (y < 0) bar = 0;
    return pal[bar];
`else
    logic [11:0] xv, yv;
    xv = 12'(x);
    yv = 12'(y);
    return {xv[7:0], yv[7:0], 8'hA5};
`endif
  endfunction

  task automatic model_reset();
    pos = 0; pend = 0;
    m1_x = 0; m1_y = 0; m1_req = 0; m1_hs = 0; m1_vs = 0; m1_fs = 0; m1_ls = 0;
    m2_de = 0; m2_hs = !HS_POL; m2_vs = !VS_POL; m2_rgb = 24'h0;
  endtask

  task automatic model_step(input bit en, input bit rs);
    if (en) begin
      m2_de  = m1_req;
      m2_hs  = m1_hs ? HS_POL : !HS_POL;
      m2_vs  = m1_vs ? VS_POL : !VS_POL;
      m2_rgb = m1_req ? exp_colour(m1_x, m1_y) : 24'h0;
      m1_x   = pos % H_TOTAL;
      m1_y   = pos / H_TOTAL;
      m1_req = (m1_x < H_ACTIVE) && (m1_y < V_ACTIVE);
      m1_hs  = (m1_x >= H_ACTIVE + H_FP) && (m1_x < H_ACTIVE + H_FP + H_SYNC);
      m1_vs  = (m1_y >= V_ACTIVE + V_FP) && (m1_y < V_ACTIVE + V_FP + V_SYNC);
      m1_fs  = (pos == 0);
      m1_ls  = (m1_x == 0);
      pos    = (rs || pend) ? 0 : (pos + 1) % FRAME;
      pend   = 0;
    end else begin
      if (rs) pend = 1;
      m1_fs = 0;
      m1_ls = 0;
    end
  endtask

  task automatic compare_all();
    check("pix_x", pix_x, m1_x);
    check("pix_y", pix_y, m1_y);
    check("pix_req", pix_req, m1_req);
    check("frame_start", frame_start, m1_fs);
    check("line_start", line_start, m1_ls);
    check("vid_de", vid_de, m2_de);
    check("vid_hs", vid_hs, m2_hs);
    check("vid_vs", vid_vs, m2_vs);
    check("vid_rgb", vid_rgb, m2_rgb);
  endtask

  task automatic cycle(input bit en, input bit rs);
    @(negedge clk);
    clk_en  = en;
    restart = rs;
    @(posedge clk);
    model_step(en, rs);
    #1;
    compare_all();
  endtask

  int hs_run, vs_run, de_run, de_lines, first_hs, first_vs, last_ls, last_fs, fs_cnt, guard;

  initial begin
    reset_n = 1'b0; clk_en = 1'b0; restart = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 compare_all();
    @(negedge clk) reset_n = 1'b1;

    // Continuous enable: sync widths/positions, DE run lengths, line and frame periods.
    hs_run = 0; vs_run = 0; de_run = 0; de_lines = 0;
    first_hs = 0; first_vs = 0; last_ls = 0; last_fs = 0;
    for (int c = 1; c <= FRAME + 10; c++) begin
      cycle(1'b1, 1'b0);
      if (c == 1) check("first_fs", {pix_x, pix_y, 7'd0, frame_start}, 32'd1);
      if (!vid_hs) begin
        if (first_hs == 0) begin
          first_hs = c;
          check("hs_start", c, H_ACTIVE + H_FP + 2);
        end
        hs_run++;
      end else if (hs_run != 0) begin
        check("hs_width", hs_run, H_SYNC);
        hs_run = 0;
      end
      if (!vid_vs) begin
        if (first_vs == 0) begin
          first_vs = c;
          check("vs_start", c, (V_ACTIVE + V_FP) * H_TOTAL + 2);
        end
        vs_run++;
      end else if (vs_run != 0) begin
        check("vs_width", vs_run, V_SYNC * H_TOTAL);
        vs_run = 0;
      end
      if (vid_de) de_run++;
      else if (de_run != 0) begin
        check("de_width", de_run, H_ACTIVE);
        de_run = 0;
        de_lines++;
      end
      if (line_start) begin
        if (last_ls != 0) check("line_period", c - last_ls, H_TOTAL);
        last_ls = c;
      end
      if (frame_start) begin
        if (last_fs != 0) begin
          check("frame_period", c - last_fs, FRAME);
          check("de_lines", de_lines, V_ACTIVE);
        end
        last_fs = c;
        de_lines = 0;
      end
    end
    check("hs_seen", first_hs != 0, 1);
    check("vs_seen", first_vs != 0, 1);

    // Restart coinciding with the natural wrap gives a single frame start.
    guard = 0;
    while (pos != FRAME - 1 && guard < 2 * FRAME) begin
      cycle(1'b1, 1'b0);
      guard++;
    end
    check("reach_wrap", pos, FRAME - 1);
    fs_cnt = 0;
    cycle(1'b1, 1'b1);
    if (frame_start) fs_cnt++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0);
      if (frame_start) fs_cnt++;
    end
    check("wrap_restart_fs", fs_cnt, 1);

    // Half-rate enable: line period doubles.
    last_ls = 0;
    for (int c = 1; c <= 4 * H_TOTAL + 10; c++) begin
      cycle(c % 2 == 1, 1'b0);
      if (line_start) begin
        if (last_ls != 0) check("line_period_half", c - last_ls, 2 * H_TOTAL);
        last_ls = c;
      end
    end

    // Restart while disabled at x=300: held pending, applied at next enabled edge, pipeline drains.
    guard = 0;
    while ((pos % H_TOTAL) != 300 && guard < 2 * H_TOTAL) begin
      cycle(1'b1, 1'b0);
      guard++;
    end
    check("reach_x300", pos % H_TOTAL, 300);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    check("drain_x", pix_x, 300);
    check("drain_fs", frame_start, 0);
    cycle(1'b1, 1'b0);
    check("restart_xy", {pix_x, pix_y}, 24'h0);
    check("restart_fs", frame_start, 1);
    cycle(1'b1, 1'b0);
    check("restart_fs_width", frame_start, 0);

    // Randomized enable and restart.
    for (int c = 0; c < 12000; c++) begin
      cycle(($urandom % 4) != 0, ($urandom % 500) == 0);
    end

    // Asynchronous reset in the middle of an active line.
    guard = 0;
    while (!(m2_de && m1_req) && guard < 2 * FRAME) begin
      cycle(1'b1, 1'b0);
      guard++;
    end
    check("reach_active", vid_de, 1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_de", vid_de, 0);
    check("async_hs", vid_hs, 1);
    compare_all();
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 2000; c++) cycle(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
